// File: rtl/async_operator_buf.sv
// rtl/async_operator_buf.sv - operand join, arithmetic op and multi-reader elastic result buffer
//
// Joins INPUT_SIZE pull-handshake operand channels, applies OP, stores results in a
// DEPTH-entry buffer read independently by OUTPUT_SIZE consumers (one read pointer each).
// Optional macro: ASYNC_OP_BUF_STATS_EN enables the saturating full-buffer stall counter.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req_l        per-channel operand request to producer
//   ack_l        per-channel producer ack pulse, din slice valid with it
//   din          operands, channel i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r        per-consumer request
//   ack_r        per-consumer one-cycle ack pulse
//   dout         per-consumer registered result, same slicing as din
//   occupancy    wr_ptr minus slowest rd_ptr
//   stall_count  cycles with operands ready but buffer full (0 unless macro defined)

module async_operator_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 2,
    parameter int DEPTH       = 4,
    parameter int OP          = 0,
    parameter int IMMEDIATE   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [INPUT_SIZE-1:0]             req_l,
    input  logic [INPUT_SIZE-1:0]             ack_l,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
    output logic [$clog2(DEPTH):0]            occupancy,
    output logic [31:0]                       stall_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]         FULL = PW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] IMM  = DATA_WIDTH'(IMMEDIATE);

    logic [INPUT_SIZE-1:0]  has;
    logic [DATA_WIDTH-1:0]  opnd [INPUT_SIZE];
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr [OUTPUT_SIZE];

    logic                   all_has;
    logic                   do_write;
    logic [OUTPUT_SIZE-1:0] do_read;
    logic [DATA_WIDTH-1:0]  result;
    logic [PW-1:0]          wr_next;
    logic [PW-1:0]          occ_next;
    logic [PW-1:0]          diff;

    assign all_has  = &has;
    // Writes look at the registered occupancy, so a slot freed this cycle is usable next cycle.
    assign do_write = all_has && (occupancy < FULL);

    // Reads compare against the registered wr_ptr; the ack_r term enforces a low cycle between acks.
    always_comb begin
        do_read = '0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            do_read[j] = req_r[j] && !ack_r[j] && (rd_ptr[j] != wr_ptr);
        end
    end

    // Binary ops fold left to right across channels; immediate ops use channel 0 only.
    always_comb begin
        result = opnd[0];
        case (OP)
            1: for (int i = 1; i < INPUT_SIZE; i++) result = result + opnd[i];
            2: for (int i = 1; i < INPUT_SIZE; i++) result = result - opnd[i];
            3: for (int i = 1; i < INPUT_SIZE; i++) result = result * opnd[i];
            4: result = opnd[0] + IMM;
            5: result = opnd[0] - IMM;
            6: result = opnd[0] * IMM;
            default: result = opnd[0];
        endcase
    end

    // Occupancy is the distance from the slowest reader, computed from next-state pointers.
    always_comb begin
        wr_next  = wr_ptr + PW'(do_write);
        occ_next = '0;
        diff     = '0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            diff = wr_next - (rd_ptr[j] + PW'(do_read[j]));
            if (diff > occ_next) occ_next = diff;
        end
    end

    // Operand handshake: an ack wins over a same-cycle request set; no request while holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_l <= '0;
            has   <= '0;
        end else begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (ack_l[i]) begin
                    has[i]   <= 1'b1;
                    req_l[i] <= 1'b0;
                end else begin
                    if (do_write) has[i] <= 1'b0;
                    if (!has[i] && !req_l[i]) req_l[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (ack_l[i]) opnd[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            occupancy <= '0;
            ack_r     <= '0;
            dout      <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++) rd_ptr[j] <= '0;
        end else begin
            wr_ptr    <= wr_next;
            occupancy <= occ_next;
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                ack_r[j] <= do_read[j];
                if (do_read[j]) begin
                    dout[j*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_ptr[j][AW-1:0]];
                    rd_ptr[j] <= rd_ptr[j] + PW'(1);
                end
            end
        end
    end

`ifdef ASYNC_OP_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (all_has && (occupancy == FULL) && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_async_operator_buf.sv
// tb/tb_async_operator_buf.sv - scoreboard bench for async_operator_buf in four configurations

module tb_async_operator_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // A: add, 2 in, 1 out, depth 4
    logic [1:0]  req_l_a, ack_l_a;
    logic [63:0] din_a;
    logic [0:0]  req_r_a, ack_r_a;
    logic [31:0] dout_a;
    logic [2:0]  occ_a;
    logic [31:0] stall_a;
    // M: muli by 3, 1 in, 1 out
    logic [0:0]  req_l_m, ack_l_m;
    logic [31:0] din_m;
    logic [0:0]  req_r_m, ack_r_m;
    logic [31:0] dout_m;
    logic [2:0]  occ_m;
    logic [31:0] stall_m;
    // P: pass, 1 in, 2 out, depth 4
    logic [0:0]  req_l_p, ack_l_p;
    logic [31:0] din_p;
    logic [1:0]  req_r_p, ack_r_p;
    logic [63:0] dout_p;
    logic [2:0]  occ_p;
    logic [31:0] stall_p;
    // W: sub, 3 in, 2 out, depth 2
    logic [2:0]  req_l_w, ack_l_w;
    logic [95:0] din_w;
    logic [1:0]  req_r_w, ack_r_w;
    logic [63:0] dout_w;
    logic [1:0]  occ_w;
    logic [31:0] stall_w;

    async_operator_buf #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4), .OP(1), .IMMEDIATE(0)) u_a (
        .clk(clk), .rst(rst), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a), .req_r(req_r_a),
        .ack_r(ack_r_a), .dout(dout_a), .occupancy(occ_a), .stall_count(stall_a));
    async_operator_buf #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(4), .OP(6), .IMMEDIATE(3)) u_m (
        .clk(clk), .rst(rst), .req_l(req_l_m), .ack_l(ack_l_m), .din(din_m), .req_r(req_r_m),
        .ack_r(ack_r_m), .dout(dout_m), .occupancy(occ_m), .stall_count(stall_m));
    async_operator_buf #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(4), .OP(0), .IMMEDIATE(0)) u_p (
        .clk(clk), .rst(rst), .req_l(req_l_p), .ack_l(ack_l_p), .din(din_p), .req_r(req_r_p),
        .ack_r(ack_r_p), .dout(dout_p), .occupancy(occ_p), .stall_count(stall_p));
    async_operator_buf #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(2), .OP(2), .IMMEDIATE(0)) u_w (
        .clk(clk), .rst(rst), .req_l(req_l_w), .ack_l(ack_l_w), .din(din_w), .req_r(req_r_w),
        .ack_r(ack_r_w), .dout(dout_w), .occupancy(occ_w), .stall_count(stall_w));

    // Streams: 0 A, 1 M, 2 P.out0, 3 P.out1, 4 W.out0, 5 W.out1
    logic [31:0] src_a [2][$];
    logic [31:0] src_w [3][$];
    logic [31:0] src_m [$];
    logic [31:0] src_p [$];
    logic [31:0] exp_q [6][$];
    logic [31:0] obs [6][$];
    int          obs_cyc [6][$];
    int          ackc_a [2][$];
    int          rd [6];
    int          pulse_err = 0;
    logic        w_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Producers: answer a raised req_l with one ack pulse if data is queued.
    initial begin
        int ia [2];
        int iw [3];
        int im;
        int ip;
        ia = '{0, 0};
        iw = '{0, 0, 0};
        im = 0;
        ip = 0;
        ack_l_a = '0; ack_l_m = '0; ack_l_p = '0; ack_l_w = '0;
        din_a = '0; din_m = '0; din_p = '0; din_w = '0;
        forever begin
            @(negedge clk);
            ack_l_a = '0; ack_l_m = '0; ack_l_p = '0; ack_l_w = '0;
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_l_a[i] && ia[i] < src_a[i].size()) begin
                        din_a[i*32 +: 32] = src_a[i][ia[i]];
                        ia[i]++;
                        ack_l_a[i] = 1'b1;
                        ackc_a[i].push_back(cyc + 1);
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (req_l_w[i] && iw[i] < src_w[i].size()) begin
                        din_w[i*32 +: 32] = src_w[i][iw[i]];
                        iw[i]++;
                        ack_l_w[i] = 1'b1;
                    end
                end
                if (req_l_m[0] && im < src_m.size()) begin
                    din_m = src_m[im]; im++; ack_l_m[0] = 1'b1;
                end
                if (req_l_p[0] && ip < src_p.size()) begin
                    din_p = src_p[ip]; ip++; ack_l_p[0] = 1'b1;
                end
            end
        end
    end

    // Random consumer gaps for the wrap configuration.
    initial begin
        req_r_w = '0;
        forever begin
            @(negedge clk);
            req_r_w = w_en ? 2'($urandom_range(0, 3)) : 2'b00;
        end
    end

    // Monitor: record every ack_r pulse and flag acks on consecutive cycles.
    initial begin
        logic [0:0] pa, pm;
        logic [1:0] pp, pw;
        pa = '0; pm = '0; pp = '0; pw = '0;
        forever begin
            @(negedge clk);
            if (ack_r_a[0]) begin obs[0].push_back(dout_a); obs_cyc[0].push_back(cyc); end
            if (ack_r_m[0]) begin obs[1].push_back(dout_m); obs_cyc[1].push_back(cyc); end
            for (int j = 0; j < 2; j++) begin
                if (ack_r_p[j]) begin obs[2+j].push_back(dout_p[j*32 +: 32]); obs_cyc[2+j].push_back(cyc); end
                if (ack_r_w[j]) begin obs[4+j].push_back(dout_w[j*32 +: 32]); obs_cyc[4+j].push_back(cyc); end
            end
            if ((ack_r_a & pa) != 0 || (ack_r_m & pm) != 0 || (ack_r_p & pp) != 0 || (ack_r_w & pw) != 0)
                pulse_err++;
            pa = ack_r_a; pm = ack_r_m; pp = ack_r_p; pw = ack_r_w;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req_r_a = '0; req_r_m = '0; req_r_p = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_l_a, ack_r_a, dout_a, occ_a, stall_a} !== '0) begin
            miscompares++; $display("FAIL reset_a: got req_l=%b ack_r=%b dout=%0h occ=%0d stall=%0d want all 0", req_l_a, ack_r_a, dout_a, occ_a, stall_a);
        end
        vectors++;
        if ({req_l_m, ack_r_m, dout_m, occ_m, stall_m} !== '0) begin
            miscompares++; $display("FAIL reset_m: got req_l=%b ack_r=%b dout=%0h occ=%0d stall=%0d want all 0", req_l_m, ack_r_m, dout_m, occ_m, stall_m);
        end
        vectors++;
        if ({req_l_p, ack_r_p, dout_p, occ_p, stall_p} !== '0) begin
            miscompares++; $display("FAIL reset_p: got req_l=%b ack_r=%b dout=%0h occ=%0d stall=%0d want all 0", req_l_p, ack_r_p, dout_p, occ_p, stall_p);
        end
        vectors++;
        if ({req_l_w, ack_r_w, dout_w, occ_w, stall_w} !== '0) begin
            miscompares++; $display("FAIL reset_w: got req_l=%b ack_r=%b dout=%0h occ=%0d stall=%0d want all 0", req_l_w, ack_r_w, dout_w, occ_w, stall_w);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        req_r_a = 1'b1;
        src_a[0].push_back(32'd3);  src_a[1].push_back(32'd4);  exp_q[0].push_back(32'd7);
        src_a[0].push_back(32'd10); src_a[1].push_back(32'd20); exp_q[0].push_back(32'd30);
        for (int k = 0; k < 100 && obs[0].size() < rd[0] + 2; k++) @(negedge clk);
        while (exp_q[0].size() > 0) begin
            logic [31:0] want;
            want = exp_q[0].pop_front();
            vectors++;
            if (rd[0] >= obs[0].size()) begin
                miscompares++; $display("FAIL add_result: got no output want %0d", want);
            end else begin
                if (obs[0][rd[0]] !== want) begin
                    miscompares++; $display("FAIL add_result: got %0d want %0d", obs[0][rd[0]], want);
                end
                rd[0]++;
            end
        end
        vectors++;
        if (obs_cyc[0].size() == 0 || ackc_a[0].size() == 0 || ackc_a[1].size() == 0) begin
            miscompares++; $display("FAIL add_latency: got no ack events want latency 2");
        end else begin
            lat = obs_cyc[0][0] - ((ackc_a[0][0] > ackc_a[1][0]) ? ackc_a[0][0] : ackc_a[1][0]);
            if (lat != 2) begin
                miscompares++; $display("FAIL add_latency: got %0d want 2", lat);
            end
        end
    endtask

    task automatic test_muli();
        req_r_m = 1'b1;
        src_m.push_back(32'h6000_0000); exp_q[1].push_back(32'h2000_0000);
        src_m.push_back(32'd5);         exp_q[1].push_back(32'd15);
        for (int k = 0; k < 100 && obs[1].size() < rd[1] + 2; k++) @(negedge clk);
        while (exp_q[1].size() > 0) begin
            logic [31:0] want;
            want = exp_q[1].pop_front();
            vectors++;
            if (rd[1] >= obs[1].size()) begin
                miscompares++; $display("FAIL muli_result: got no output want %0h", want);
            end else begin
                if (obs[1][rd[1]] !== want) begin
                    miscompares++; $display("FAIL muli_result: got %0h want %0h", obs[1][rd[1]], want);
                end
                rd[1]++;
            end
        end
    endtask

    task automatic test_fanout_stall();
        logic [31:0] s0;
        logic [31:0] want_stall;
`ifdef ASYNC_OP_BUF_STATS_EN
        want_stall = 32'd10;
`else
        want_stall = 32'd0;
`endif
        req_r_p = 2'b01;
        for (int v = 1; v <= 6; v++) begin
            src_p.push_back(32'(v));
            exp_q[2].push_back(32'(v));
            exp_q[3].push_back(32'(v));
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (obs[2].size() - rd[2] != 4) begin
            miscompares++; $display("FAIL fanout_out0_count: got %0d want 4", obs[2].size() - rd[2]);
        end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] want;
            want = exp_q[2].pop_front();
            vectors++;
            if (rd[2] >= obs[2].size()) begin
                miscompares++; $display("FAIL fanout_out0: got no output want %0d", want);
            end else begin
                if (obs[2][rd[2]] !== want) begin
                    miscompares++; $display("FAIL fanout_out0: got %0d want %0d", obs[2][rd[2]], want);
                end
                rd[2]++;
            end
        end
        vectors++;
        if (occ_p !== 3'd4) begin
            miscompares++; $display("FAIL fanout_occupancy: got %0d want 4", occ_p);
        end
        vectors++;
        if (req_l_p !== 1'b0) begin
            miscompares++; $display("FAIL fanout_backpressure: got req_l=%b want 0", req_l_p);
        end
        s0 = stall_p;
        repeat (10) @(negedge clk);
        vectors++;
        if (stall_p - s0 !== want_stall) begin
            miscompares++; $display("FAIL stall_count: got delta %0d want %0d", stall_p - s0, want_stall);
        end
        req_r_p = 2'b11;
        for (int k = 0; k < 200 && (obs[3].size() < rd[3] + 6 || obs[2].size() < rd[2] + 2); k++) @(negedge clk);
        for (int s = 2; s <= 3; s++) begin
            while (exp_q[s].size() > 0) begin
                logic [31:0] want;
                want = exp_q[s].pop_front();
                vectors++;
                if (rd[s] >= obs[s].size()) begin
                    miscompares++; $display("FAIL fanout_drain%0d: got no output want %0d", s - 2, want);
                end else begin
                    if (obs[s][rd[s]] !== want) begin
                        miscompares++; $display("FAIL fanout_drain%0d: got %0d want %0d", s - 2, obs[s][rd[s]], want);
                    end
                    rd[s]++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        req_r_a = 1'b0;
        for (int v = 0; v < 3; v++) begin
            src_a[0].push_back(32'(11 + v));
            src_a[1].push_back(32'(21 + v));
        end
        src_a[0].push_back(32'd14);
        repeat (30) @(negedge clk);
        vectors++;
        if (occ_a !== 3'd3 || req_l_a !== 2'b10) begin
            miscompares++; $display("FAIL pre_reset_state: got occ=%0d req_l=%b want occ=3 req_l=10", occ_a, req_l_a);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({occ_a, ack_r_a, dout_a, req_l_a} !== '0) begin
            miscompares++; $display("FAIL mid_reset: got occ=%0d ack_r=%b dout=%0h req_l=%b want all 0", occ_a, ack_r_a, dout_a, req_l_a);
        end
        rst = 1'b0;
        rd[0] = obs[0].size();
        src_a[0].push_back(32'd5); src_a[1].push_back(32'd6); exp_q[0].push_back(32'd11);
        req_r_a = 1'b1;
        for (int k = 0; k < 100 && obs[0].size() < rd[0] + 1; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        vectors++;
        if (obs[0].size() - rd[0] != 1) begin
            miscompares++; $display("FAIL post_reset_count: got %0d want 1", obs[0].size() - rd[0]);
        end
        begin
            logic [31:0] want;
            want = exp_q[0].pop_front();
            vectors++;
            if (rd[0] >= obs[0].size()) begin
                miscompares++; $display("FAIL post_reset_result: got no output want %0d", want);
            end else begin
                if (obs[0][rd[0]] !== want) begin
                    miscompares++; $display("FAIL post_reset_result: got %0d want %0d", obs[0][rd[0]], want);
                end
                rd[0] = obs[0].size();
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a, b, c;
        for (int t = 0; t < 100; t++) begin
            a = $urandom; b = $urandom; c = $urandom;
            src_w[0].push_back(a); src_w[1].push_back(b); src_w[2].push_back(c);
            exp_q[4].push_back(a - b - c);
            exp_q[5].push_back(a - b - c);
        end
        w_en = 1'b1;
        for (int k = 0; k < 5000 && (obs[4].size() < rd[4] + 100 || obs[5].size() < rd[5] + 100); k++) @(negedge clk);
        w_en = 1'b0;
        repeat (10) @(negedge clk);
        for (int s = 4; s <= 5; s++) begin
            vectors++;
            if (obs[s].size() - rd[s] != 100) begin
                miscompares++; $display("FAIL wrap_count%0d: got %0d want 100", s - 4, obs[s].size() - rd[s]);
            end
            while (exp_q[s].size() > 0) begin
                logic [31:0] want;
                want = exp_q[s].pop_front();
                vectors++;
                if (rd[s] >= obs[s].size()) begin
                    miscompares++; $display("FAIL wrap_out%0d: got no output want %0h", s - 4, want);
                end else begin
                    if (obs[s][rd[s]] !== want) begin
                        miscompares++; $display("FAIL wrap_out%0d: got %0h want %0h", s - 4, obs[s][rd[s]], want);
                    end
                    rd[s]++;
                end
            end
        end
        vectors++;
        if (occ_w !== 2'd0) begin
            miscompares++; $display("FAIL wrap_occupancy: got %0d want 0", occ_w);
        end
        vectors++;
        if (pulse_err != 0) begin
            miscompares++; $display("FAIL ack_pulse_gap: got %0d adjacent acks want 0", pulse_err);
        end
    endtask

    initial begin
        rd = '{0, 0, 0, 0, 0, 0};
        test_reset();
        test_add();
        test_muli();
        test_fanout_stall();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
